// File: rtl/q_policy_walker.sv
// rtl/q_policy_walker.sv - Q-table policy walker
// Scans four actions per cell through one read port, masks illegal moves, then handshakes each move out.
module q_policy_walker #(
  parameter int          GRID_W     = 6,
  parameter int          GRID_H     = 6,
  parameter int          STATE_W    = 6,
  parameter int          Q_W        = 32,
  parameter int          N_BLOCK    = 16,
  parameter int          MAX_STEPS  = 64,
  parameter int          EPS_MODE   = 0,
  parameter logic [7:0]  EPS_THRESH = 8'd26
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [STATE_W-1:0]         start_state,
  input  logic [STATE_W-1:0]         target_state,
  input  logic [N_BLOCK*STATE_W-1:0] blocked,
  output logic [STATE_W+1:0]         q_rd_addr,
  input  logic [Q_W-1:0]             q_rd_data,
  output logic                       move_req,
  output logic [STATE_W-1:0]         next_state,
  input  logic                       move_complete,
  output logic                       timer_start,
  output logic [STATE_W-1:0]         cur_state,
  output logic [7:0]                 step_count,
  output logic                       busy,
  output logic                       target_reached,
  output logic                       timeout,
  output logic                       stuck
);

  typedef enum logic [2:0] {IDLE, SCAN, DECIDE, MOVE, CHECK, DONE} state_t;

  localparam logic [STATE_W-1:0] GW       = STATE_W'(GRID_W);
  localparam logic [STATE_W-1:0] ROW_LAST = STATE_W'(GRID_H - 1);
  localparam logic [STATE_W-1:0] COL_LAST = STATE_W'(GRID_W - 1);
  localparam logic [STATE_W-1:0] EMPTY    = '1;

  state_t                    state, state_nx;
  logic [STATE_W-1:0]        tgt;
  logic [N_BLOCK*STATE_W-1:0] blk_q;
  logic [2:0]                sc;
  logic signed [Q_W-1:0]     best_val;
  logic [1:0]                best_act;
  logic                      best_ok;
  logic [15:0]               lfsr;
  logic                      mv_first;

  logic [STATE_W-1:0]        row, col;
  logic [STATE_W-1:0]        dest [4];
  logic [3:0]                legal;
  logic [1:0]                scan_a, rnd_a, chosen;
  logic                      better, use_rnd;
  logic signed [Q_W-1:0]     q_s;

  // Legality of all four moves from the current cell, including the blocked-cell mask
  always_comb begin
    row     = cur_state / GW;
    col     = cur_state % GW;
    dest[0] = cur_state - GW;
    dest[1] = cur_state + GW;
    dest[2] = cur_state - 1'b1;
    dest[3] = cur_state + 1'b1;
    legal   = {col != COL_LAST, col != '0, row != ROW_LAST, row != '0};
    for (int a = 0; a < 4; a++) begin
      for (int i = 0; i < N_BLOCK; i++) begin
        if (blk_q[i*STATE_W +: STATE_W] == dest[a] && blk_q[i*STATE_W +: STATE_W] != EMPTY)
          legal[a] = 1'b0;
      end
    end
  end

  // Read data lags the address by one cycle, so SCAN cycle n evaluates action n-1
  assign scan_a  = 2'(sc - 3'd1);
  assign q_s     = $signed(q_rd_data);
  assign better  = legal[scan_a] && (!best_ok || q_s > best_val);
  assign rnd_a   = lfsr[9:8];
  assign use_rnd = (EPS_MODE != 0) && (lfsr[7:0] < EPS_THRESH) && legal[rnd_a];
  assign chosen  = use_rnd ? rnd_a : best_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (start_state == target_state) ? DONE : SCAN;
      SCAN:    if (sc == 3'd4) state_nx = DECIDE;
      DECIDE:  state_nx = (|legal) ? MOVE : DONE;
      MOVE:    if (move_complete) state_nx = CHECK;
      CHECK:   state_nx = (cur_state == tgt || step_count == 8'(MAX_STEPS)) ? DONE : SCAN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    move_req    = (state == MOVE);
    timer_start = (state == MOVE) && mv_first;
    q_rd_addr   = '0;
    if (state == SCAN && sc < 3'd4) q_rd_addr = {cur_state, sc[1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt <= '0; blk_q <= '0; sc <= '0; best_val <= '0; best_act <= '0; best_ok <= 1'b0;
      lfsr <= 16'hACE1; mv_first <= 1'b0; next_state <= '0; cur_state <= '0;
      step_count <= '0; busy <= 1'b0; target_reached <= 1'b0; timeout <= 1'b0; stuck <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur_state      <= start_state;
          tgt            <= target_state;
          blk_q          <= blocked;
          step_count     <= '0;
          target_reached <= (start_state == target_state);
          timeout        <= 1'b0;
          stuck          <= 1'b0;
          busy           <= 1'b1;
          sc             <= '0;
          best_ok        <= 1'b0;
        end
        SCAN: begin
          sc <= sc + 3'd1;
          if (sc != 3'd0 && better) begin
            best_val <= q_s;
            best_act <= scan_a;
            best_ok  <= 1'b1;
          end
        end
        DECIDE: begin
          lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
          if (!(|legal)) stuck <= 1'b1;
          else begin
            next_state <= dest[chosen];
            mv_first   <= 1'b1;
          end
        end
        MOVE: begin
          mv_first <= 1'b0;
          if (move_complete) begin
            cur_state <= next_state;
            if (step_count != 8'hFF) step_count <= step_count + 8'd1;
          end
        end
        CHECK: begin
          if (cur_state == tgt)                    target_reached <= 1'b1;
          else if (step_count == 8'(MAX_STEPS))    timeout        <= 1'b1;
          sc      <= '0;
          best_ok <= 1'b0;
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q_policy_walker.sv
// tb/tb_q_policy_walker.sv - directed bench for q_policy_walker
// Three instances: default greedy, MAX_STEPS=4, and epsilon mode with threshold 0xFF.
module tb_q_policy_walker;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_t, start_e;
  logic [5:0] start_state, target_state;
  logic [95:0] blocked;
  logic mc_auto, mc_manual;
  logic [31:0] qtab [0:255];

  logic [7:0]  a_addr, t_addr, e_addr;
  logic [31:0] a_qd, t_qd, e_qd;
  logic a_mr, t_mr, e_mr, a_ts, t_ts, e_ts;
  logic [5:0] a_ns, t_ns, e_ns, a_cur, t_cur, e_cur;
  logic [7:0] a_sc, t_sc, e_sc;
  logic a_busy, t_busy, e_busy, a_tr, t_tr, e_tr, a_to, t_to, e_to, a_st, t_st, e_st;
  logic a_mc, t_mc, e_mc;

  int n_vec = 0, n_err = 0;
  int n, stuck_n, mr_seen, stable, tp, pos, expd;
  logic [5:0] seen [$];
  logic [15:0] lfsr_m;
  int exp_path [10] = '{1, 2, 3, 4, 5, 11, 17, 23, 29, 35};

  always #5 clk = ~clk;

  assign a_mc = mc_auto ? a_mr : mc_manual;
  assign t_mc = mc_auto ? t_mr : mc_manual;
  assign e_mc = mc_auto ? e_mr : mc_manual;

  always @(posedge clk) begin
    a_qd <= qtab[a_addr];
    t_qd <= qtab[t_addr];
    e_qd <= qtab[e_addr];
  end

  q_policy_walker dut (
    .clk(clk), .rst(rst), .start(start_a), .start_state(start_state), .target_state(target_state),
    .blocked(blocked), .q_rd_addr(a_addr), .q_rd_data(a_qd), .move_req(a_mr), .next_state(a_ns),
    .move_complete(a_mc), .timer_start(a_ts), .cur_state(a_cur), .step_count(a_sc), .busy(a_busy),
    .target_reached(a_tr), .timeout(a_to), .stuck(a_st));

  q_policy_walker #(.MAX_STEPS(4)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .start_state(start_state), .target_state(target_state),
    .blocked(blocked), .q_rd_addr(t_addr), .q_rd_data(t_qd), .move_req(t_mr), .next_state(t_ns),
    .move_complete(t_mc), .timer_start(t_ts), .cur_state(t_cur), .step_count(t_sc), .busy(t_busy),
    .target_reached(t_tr), .timeout(t_to), .stuck(t_st));

  q_policy_walker #(.EPS_MODE(1), .EPS_THRESH(8'hFF)) dut_e (
    .clk(clk), .rst(rst), .start(start_e), .start_state(start_state), .target_state(target_state),
    .blocked(blocked), .q_rd_addr(e_addr), .q_rd_data(e_qd), .move_req(e_mr), .next_state(e_ns),
    .move_complete(e_mc), .timer_start(e_ts), .cur_state(e_cur), .step_count(e_sc), .busy(e_busy),
    .target_reached(e_tr), .timeout(e_to), .stuck(e_st));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < 256; i++) qtab[i] = 32'd0;
  endtask

  task automatic set_blocks(input int b0, input int b1, input int b2, input int b3);
    blocked = '1;
    if (b0 >= 0) blocked[0 +: 6]  = 6'(b0);
    if (b1 >= 0) blocked[6 +: 6]  = 6'(b1);
    if (b2 >= 0) blocked[12 +: 6] = 6'(b2);
    if (b3 >= 0) blocked[18 +: 6] = 6'(b3);
  endtask

  // Leaves the bench at the negedge right after the start edge
  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) start_a = 1'b1; else if (which == 1) start_t = 1'b1; else start_e = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_t = 1'b0; start_e = 1'b0;
  endtask

  task automatic run_a(input int limit);
    n = 0; stuck_n = -1; mr_seen = 0; seen.delete();
    do begin
      @(negedge clk);
      n++;
      if (a_ts) seen.push_back(a_ns);
      if (a_mr) mr_seen++;
      if (a_st && stuck_n < 0) stuck_n = n;
    end while (a_busy && n < limit);
  endtask

  function automatic int m_dest(input int p, input int a);
    int r, c, d;
    r = p / 6; c = p % 6;
    case (a)
      0: d = (r == 0) ? -1 : p - 6;
      1: d = (r == 5) ? -1 : p + 6;
      2: d = (c == 0) ? -1 : p - 1;
      default: d = (c == 5) ? -1 : p + 1;
    endcase
    if (d == 35) d = -1;
    return d;
  endfunction

  initial begin
    rst = 1'b1; start_a = 0; start_t = 0; start_e = 0; mc_auto = 1'b1; mc_manual = 1'b0;
    start_state = 0; target_state = 0; set_blocks(-1, -1, -1, -1); clear_q();
    repeat (3) @(negedge clk);
    chk("reset_outs", {a_busy, a_mr, a_ts, a_tr, a_to, a_st, a_cur, a_sc, a_ns, a_addr}, 64'd0);
    rst = 1'b0;

    // Greedy walk along row 0 then column 5
    for (int s = 0; s < 5; s++) qtab[s*4 + 3] = 32'd10;
    qtab[5*4 + 1] = 10; qtab[11*4 + 1] = 10; qtab[17*4 + 1] = 10; qtab[23*4 + 1] = 10; qtab[29*4 + 1] = 10;
    start_state = 0; target_state = 35;
    pulse(0); run_a(300);
    chk("path_cycles", n, 81);
    chk("path_pulses", seen.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("path_step%0d", i), seen[i], exp_path[i]);
    chk("path_steps", a_sc, 10);
    chk("path_flags", {a_tr, a_to, a_st}, 3'b100);
    chk("path_cur", a_cur, 35);

    // Best move blocked
    clear_q(); qtab[3] = 100; qtab[1] = 5; set_blocks(1, -1, -1, -1);
    target_state = 6; pulse(0); run_a(100);
    chk("blk_next", seen[0], 6);
    chk("blk_done", {a_tr, a_sc}, {1'b1, 8'd1});

    // Tie resolves to lowest legal index
    clear_q(); for (int a = 0; a < 4; a++) qtab[a] = 7; set_blocks(-1, -1, -1, -1);
    pulse(0); run_a(100);
    chk("tie_next", seen[0], 6);

    // Most negative Q on the only legal action
    clear_q(); qtab[0] = 50; qtab[1] = 32'h80000000; qtab[2] = 50; qtab[3] = 100; set_blocks(1, -1, -1, -1);
    pulse(0); run_a(100);
    chk("minq_next", seen[0], 6);

    // Boxed-in start cell
    clear_q(); set_blocks(1, 6, 8, 13); start_state = 7; target_state = 0;
    pulse(0); run_a(100);
    chk("stuck_latency", stuck_n, 6);
    chk("stuck_no_move", mr_seen, 0);
    chk("stuck_flags", {a_tr, a_to, a_st, a_sc}, {3'b001, 8'd0});

    // Oscillation hits the step limit
    clear_q(); qtab[3] = 10; qtab[1*4 + 2] = 10; set_blocks(-1, -1, -1, -1);
    start_state = 0; target_state = 35;
    pulse(1);
    n = 0; while (t_busy && n < 200) begin @(negedge clk); n++; end
    chk("to_flags", {t_tr, t_to, t_st}, 3'b010);
    chk("to_steps", t_sc, 4);
    chk("to_cur", t_cur, 0);

    // Delayed completion
    clear_q(); qtab[3] = 10; target_state = 1; mc_auto = 1'b0; mc_manual = 1'b0;
    pulse(0);
    n = 0; while (!a_mr && n < 50) begin @(negedge clk); n++; end
    chk("hs_first_move", n, 6);
    stable = 0; tp = a_ts ? 1 : 0;
    repeat (20) begin
      @(negedge clk);
      if (a_mr && a_ns == 6'd1) stable++;
      if (a_ts) tp++;
    end
    chk("hs_stable", stable, 20);
    chk("hs_timer_pulses", tp, 1);
    mc_manual = 1'b1; @(negedge clk); mc_manual = 1'b0;
    chk("hs_released", {a_mr, a_sc}, {1'b0, 8'd1});
    run_a(50);
    chk("hs_done", {a_busy, a_tr}, 2'b01);

    // Reset in the middle of the third move
    clear_q();
    for (int s = 0; s < 5; s++) qtab[s*4 + 3] = 32'd10;
    target_state = 35; mc_manual = 1'b1;
    pulse(0);
    n = 0; while (!(a_ts && a_ns == 6'd3) && n < 100) begin @(negedge clk); n++; end
    mc_manual = 1'b0;
    @(negedge clk);
    chk("rst_pre", {a_mr, a_sc, a_cur, a_ns}, {1'b1, 8'd2, 6'd2, 6'd3});
    #1 rst = 1'b1;
    #1 chk("rst_async", {a_busy, a_mr, a_ts, a_tr, a_to, a_st, a_cur, a_sc, a_ns, a_addr}, 64'd0);
    @(negedge clk); rst = 1'b0; mc_auto = 1'b1;

    // Start already on target
    start_state = 9; target_state = 9;
    pulse(0);
    chk("same_flag", {a_busy, a_tr}, 2'b11);
    run_a(20);
    chk("same_done", n, 1);
    chk("same_moves", {seen.size(), a_sc}, {32'd0, 8'd0});

    // Epsilon-greedy on an open grid; target cell is blocked so the walk keeps going
    clear_q(); set_blocks(35, -1, -1, -1); start_state = 14; target_state = 35;
    lfsr_m = 16'hACE1; pos = 14;
    pulse(2);
    for (int k = 0; k < 16; k++) begin
      n = 0; while (!e_ts && n < 40) begin @(negedge clk); n++; end
      expd = -1;
      if (lfsr_m[7:0] < 8'hFF) expd = m_dest(pos, int'(lfsr_m[9:8]));
      for (int a = 0; a < 4 && expd < 0; a++) expd = m_dest(pos, a);
      chk($sformatf("eps_step%0d", k), e_ns, 6'(expd));
      pos = expd;
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
      @(negedge clk);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/q_policy_walker.md
Name: q_policy_walker

Overview:
- Parametrised successor to the Q-table exploit stage. Walks a trained Q-table on a GRID_W x GRID_H maze from start_state to target_state.
- Each step: scan all actions through a single Q-table read port, mask off-grid and blocked moves, pick the best (or random, in epsilon mode), then hand the move to the motion layer with a req/complete handshake.
- Adds what the fixed exploit stage lacks: sized grid, read-port Q access, step limit/timeout, stuck detection, optional epsilon-greedy exploration.

Parameters:
- GRID_W, 6, maze columns
- GRID_H, 6, maze rows
- STATE_W, 6, state index width; must satisfy 2^STATE_W >= GRID_W*GRID_H
- Q_W, 32, Q value width, signed two's complement
- N_BLOCK, 16, number of blocked-cell slots
- MAX_STEPS, 64, moves allowed before timeout
- EPS_MODE, 0, 0 = pure greedy, 1 = epsilon-greedy
- EPS_THRESH, 8'd26, random-action threshold (about 10%)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a walk
- start_state  in  STATE_W  initial cell
- target_state  in  STATE_W  goal cell
- blocked  in  N_BLOCK*STATE_W  packed blocked-cell list; slot i = bits [i*STATE_W +: STATE_W]; value 2^STATE_W-1 = empty slot
- q_rd_addr  out  STATE_W+2  Q-table read address {state, action}
- q_rd_data  in  Q_W  Q value; valid exactly 1 cycle after q_rd_addr
- move_req  out  1  move request to motion layer
- next_state  out  STATE_W  cell being moved to; valid while move_req=1
- move_complete  in  1  motion done; may be a pulse or a level
- timer_start  out  1  one-cycle pulse when a move is issued
- cur_state  out  STATE_W  current cell
- step_count  out  8  moves completed in this walk
- busy  out  1  walk in progress
- target_reached  out  1  sticky until next start
- timeout  out  1  sticky until next start
- stuck  out  1  sticky until next start; no legal action existed

Behaviour:
- Reset: all outputs 0, FSM=IDLE, LFSR=16'hACE1. Reset mid-walk aborts immediately; move_req drops asynchronously.
- Cell indexing: state = row*GRID_W + col.
- Action moves:
  - 0 up: state - GRID_W; illegal if row = 0
  - 1 down: state + GRID_W; illegal if row = GRID_H-1
  - 2 left: state - 1; illegal if col = 0
  - 3 right: state + 1; illegal if col = GRID_W-1
  - Also illegal if the destination matches any blocked slot.
- IDLE:
  - On start: latch start_state, target_state and blocked; cur_state = start_state; clear step_count and the three sticky flags; set busy=1.
  - If start_state == target_state: target_reached=1 next cycle, go to DONE. Otherwise go to SCAN.
- SCAN (5 cycles):
  - Drive q_rd_addr = {cur_state, a} for a = 0..3 on cycles 0..3.
  - Data for action a is captured on cycle a+1.
  - Keep a running best: signed compare, strictly greater wins, so ties resolve to the lowest action index.
  - Illegal actions are skipped.
- DECIDE (1 cycle):
  - No legal action: stuck=1, go to DONE.
  - EPS_MODE=1 and LFSR[7:0] < EPS_THRESH: action = LFSR[9:8] if legal, else greedy.
  - LFSR advances once per DECIDE. Taps 16,14,13,11.
  - Set next_state to the chosen destination; go to MOVE.
- MOVE:
  - move_req=1, with timer_start pulsed on the first MOVE cycle only.
  - Hold until move_complete=1 is sampled. Then cur_state = next_state, step_count++, move_req=0, go to CHECK.
  - move_complete outside MOVE is ignored.
- CHECK (1 cycle):
  - cur_state == target_state: target_reached=1, go to DONE.
  - Else step_count == MAX_STEPS: timeout=1, go to DONE.
  - Else go to SCAN.
  - target_reached takes priority when both conditions hold.
- DONE: busy=0, go to IDLE; sticky flags are held.
- start while busy=1 is ignored.
- step_count saturates at 255.
- Per-step latency with move_complete asserted on the first MOVE cycle: 5 SCAN + 1 DECIDE + 1 MOVE + 1 CHECK = 8 cycles.

Test Plan:
- Greedy path, 6x6 grid, no blocks, start=0, target=35. Q favours right on row 0 and down on col 5. Expect next_state sequence 1,2,3,4,5,11,17,23,29,35; step_count=10; target_reached=1; 10 timer_start pulses.
- Blocked best move: start=0, cell 1 blocked, Q(0,right)=100, Q(0,down)=5. Expect next_state=6.
- Tie and boundary: state 0 with all Q = 7. Up and left are illegal, so down is chosen (lowest legal index); next_state=6. Q=0x80000000 on the only legal action must still be selected.
- Stuck and timeout:
  - Start=7 with cells 1, 6, 8, 13 blocked: expect stuck=1 after 6 cycles and no move_req.
  - MAX_STEPS=4 with a Q-table oscillating 0<->1: expect timeout=1 with step_count=4.
- Handshake and reset:
  - Delay move_complete by 20 cycles: move_req and next_state must stay stable throughout.
  - Assert rst mid-MOVE: all outputs 0 immediately; a subsequent start works normally.
  - start=target=9: expect target_reached=1 with zero moves.
- Epsilon mode: EPS_MODE=1, EPS_THRESH=8'hFF. Over 16 steps on an open grid, the chosen action must match LFSR[9:8] whenever that action is legal.
